// File: rtl/pingpong_buffer_slv.sv
// Purpose : AXI4 write slave filling two DEPTH_g-word banks ping-pong, draining full banks on a valid/ready stream.
// Latency : a bank is visible on m_valid_o in the cycle after its closing write edge; B follows wlast by one edge.
// Backpr. : wready drops while the current fill bank is still full; the drain stalls on m_ready_i.
//
// Ports   : clk_i/rst_n_i (async active-low), grant_i (AW arbitration gate),
//           s_axi_aw*/s_axi_w*/s_axi_b* (AXI4 write slave, awaddr/awlen ignored),
//           m_valid_o/m_ready_i/m_data_o/m_last_o (drain stream),
//           flush_i (only when PPBUF_FLUSH_EN is defined: closes a partial bank from A_IDLE).
module pingpong_buffer_slv #(
  parameter int AXI_DW_g = 64,
  parameter int AXI_AW_g = 32,
  parameter int DEPTH_g  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  grant_i,
  output logic                  s_axi_awready_o,
  input  logic                  s_axi_awvalid_i,
  input  logic [AXI_AW_g-1:0]   s_axi_awaddr_i,
  input  logic [7:0]            s_axi_awlen_i,
  input  logic [2:0]            s_axi_awsize_i,
  input  logic [1:0]            s_axi_awburst_i,
  output logic                  s_axi_wready_o,
  input  logic                  s_axi_wvalid_i,
  input  logic [AXI_DW_g-1:0]   s_axi_wdata_i,
  input  logic [AXI_DW_g/8-1:0] s_axi_wstrb_i,
  input  logic                  s_axi_wlast_i,
  input  logic                  s_axi_bready_i,
  output logic                  s_axi_bvalid_o,
  output logic [1:0]            s_axi_bresp_o,
`ifdef PPBUF_FLUSH_EN
  input  logic                  flush_i,
`endif
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [AXI_DW_g-1:0]   m_data_o,
  output logic                  m_last_o
);

  localparam int          IW      = $clog2(DEPTH_g);
  localparam int          SW      = AXI_DW_g / 8;
  localparam logic [2:0]  SIZE_OK = 3'($clog2(SW));
  localparam logic [1:0]  INCR    = 2'b01;

  typedef enum logic [1:0] {A_IDLE, A_DATA, A_RESP} a_state_t;

  a_state_t            r_state;
  a_state_t            w_state_nxt;
  logic                r_err;
  logic [1:0]          r_full;
  logic [IW:0]         r_len [2];
  logic                r_fill_bank;
  logic [IW-1:0]       r_fill_idx;
  logic                r_drain_bank;
  logic [IW-1:0]       r_drain_idx;
  logic [AXI_DW_g-1:0] r_mem [2][DEPTH_g];

  logic        w_awready, w_wready, w_bvalid;
  logic        w_aw_hs, w_w_hs, w_store, w_fill_wrap, w_flush, w_close;
  logic [IW:0] w_close_len;
  logic        w_m_valid, w_last_beat, w_m_hs;
  logic [1:0]  w_set, w_clr;
  logic        w_unused_ok;

  // Address and burst length carry no information for this buffer; wlast ends a burst.
  assign w_unused_ok = ^{s_axi_awaddr_i, s_axi_awlen_i};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= A_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_awready   = 1'b0;
    w_wready    = 1'b0;
    w_bvalid    = 1'b0;
    case (r_state)
      A_IDLE: begin
        w_awready = grant_i;
        if (grant_i && s_axi_awvalid_i) w_state_nxt = A_DATA;
      end
      A_DATA: begin
        w_wready = !r_full[r_fill_bank];
        if (s_axi_wvalid_i && w_wready && s_axi_wlast_i) w_state_nxt = A_RESP;
      end
      A_RESP: begin
        w_bvalid = 1'b1;
        if (s_axi_bready_i) w_state_nxt = A_IDLE;
      end
      default: w_state_nxt = A_IDLE;
    endcase
  end

  assign s_axi_awready_o = w_awready;
  assign s_axi_wready_o  = w_wready;
  assign s_axi_bvalid_o  = w_bvalid;
  assign s_axi_bresp_o   = (r_state == A_RESP && r_err) ? 2'b10 : 2'b00;

  assign w_aw_hs = (r_state == A_IDLE) && grant_i && s_axi_awvalid_i;
  assign w_w_hs  = (r_state == A_DATA) && s_axi_wvalid_i && w_wready;
  // Errored bursts are still handshaken but never touch storage or the fill pointer.
  assign w_store     = w_w_hs && !r_err;
  assign w_fill_wrap = w_store && (r_fill_idx == IW'(DEPTH_g - 1));

`ifdef PPBUF_FLUSH_EN
  assign w_flush = (r_state == A_IDLE) && flush_i && (r_fill_idx != '0) && !r_full[r_fill_bank];
`else
  assign w_flush = 1'b0;
`endif

  // Flush only fires in A_IDLE and a wrap only in A_DATA, so they never coincide.
  assign w_close     = w_fill_wrap || w_flush;
  assign w_close_len = w_fill_wrap ? (IW+1)'(DEPTH_g) : {1'b0, r_fill_idx};

  assign w_m_valid   = r_full[r_drain_bank];
  assign w_last_beat = w_m_valid && ({1'b0, r_drain_idx} == (r_len[r_drain_bank] - (IW+1)'(1)));
  assign w_m_hs      = w_m_valid && m_ready_i;

  // The filler only closes a non-full bank and the drain only clears a full one,
  // so set and clear always target different banks.
  assign w_set = w_close ? (r_fill_bank ? 2'b10 : 2'b01) : 2'b00;
  assign w_clr = (w_m_hs && w_last_beat) ? (r_drain_bank ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_err        <= 1'b0;
      r_full       <= 2'b00;
      r_len[0]     <= '0;
      r_len[1]     <= '0;
      r_fill_bank  <= 1'b0;
      r_fill_idx   <= '0;
      r_drain_bank <= 1'b0;
      r_drain_idx  <= '0;
    end else begin
      if (w_aw_hs) r_err <= (s_axi_awburst_i != INCR) || (s_axi_awsize_i != SIZE_OK);

      r_full <= (r_full | w_set) & ~w_clr;

      if (w_close) begin
        r_len[r_fill_bank] <= w_close_len;
        r_fill_idx         <= '0;
        r_fill_bank        <= ~r_fill_bank;
      end else if (w_store) begin
        r_fill_idx <= r_fill_idx + IW'(1);
      end

      if (w_m_hs) begin
        if (w_last_beat) begin
          r_drain_idx  <= '0;
          r_drain_bank <= ~r_drain_bank;
        end else begin
          r_drain_idx <= r_drain_idx + IW'(1);
        end
      end
    end
  end

  // Bank storage is deliberately unreset; byte lanes with a low strobe keep old data.
  always_ff @(posedge clk_i) begin
    if (w_store) begin
      for (int i = 0; i < SW; i++) begin
        if (s_axi_wstrb_i[i]) r_mem[r_fill_bank][r_fill_idx][8*i +: 8] <= s_axi_wdata_i[8*i +: 8];
      end
    end
  end

  assign m_valid_o = w_m_valid;
  assign m_data_o  = r_mem[r_drain_bank][r_drain_idx];
  assign m_last_o  = w_last_beat;

endmodule

// File: tb/tb_pingpong_buffer_slv.sv
module tb_pingpong_buffer_slv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        grant = 1'b0;
  logic        awready, awvalid = 1'b0;
  logic [31:0] awaddr = '0;
  logic [7:0]  awlen = '0;
  logic [2:0]  awsize = 3'd3;
  logic [1:0]  awburst = 2'b01;
  logic        wready, wvalid = 1'b0;
  logic [63:0] wdata = '0;
  logic [7:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        bready = 1'b0, bvalid;
  logic [1:0]  bresp;
  logic        m_valid, m_ready = 1'b0, m_last;
  logic [63:0] m_data;
`ifdef PPBUF_FLUSH_EN
  logic        flush = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  pingpong_buffer_slv #(.AXI_DW_g(64), .AXI_AW_g(32), .DEPTH_g(16)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .grant_i(grant),
    .s_axi_awready_o(awready), .s_axi_awvalid_i(awvalid), .s_axi_awaddr_i(awaddr),
    .s_axi_awlen_i(awlen), .s_axi_awsize_i(awsize), .s_axi_awburst_i(awburst),
    .s_axi_wready_o(wready), .s_axi_wvalid_i(wvalid), .s_axi_wdata_i(wdata),
    .s_axi_wstrb_i(wstrb), .s_axi_wlast_i(wlast),
    .s_axi_bready_i(bready), .s_axi_bvalid_o(bvalid), .s_axi_bresp_o(bresp),
`ifdef PPBUF_FLUSH_EN
    .flush_i(flush),
`endif
    .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data), .m_last_o(m_last)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_aw(input logic [1:0] burst, input logic [2:0] size, input logic [7:0] len);
    int n = 0;
    @(negedge clk);
    awvalid = 1'b1; awburst = burst; awsize = size; awlen = len; awaddr = $urandom;
    while (!awready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("aw_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    chk("awready_low_in_burst", awready, 1'b0);
  endtask

  task automatic w_beat(input logic [63:0] d, input logic [7:0] s, input logic l);
    int n = 0;
    @(negedge clk);
    wvalid = 1'b1; wdata = d; wstrb = s; wlast = l;
    while (!wready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("w_timeout", 1'b0, 1'b1);
    @(posedge clk); #1;
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  // Called #1 after the wlast edge.
  task automatic check_b(input logic [1:0] resp);
    chk("bvalid_after_wlast", bvalid, 1'b1);
    chk("bresp", bresp, resp);
    @(negedge clk); bready = 1'b1;
    @(posedge clk); #1; bready = 1'b0;
    chk("bvalid_cleared", bvalid, 1'b0);
  endtask

  task automatic burst(input int n, input logic [63:0] base, input logic [1:0] bt,
                       input logic [2:0] sz, input logic [1:0] resp);
    send_aw(bt, sz, 8'(n - 1));
    for (int i = 0; i < n; i++) w_beat(base + 64'(i), 8'hFF, i == n - 1);
    check_b(resp);
  endtask

  task automatic drain(input int n, input logic [63:0] base, input logic [63:0] first);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      @(negedge clk); m_ready = 1'b1;
      while (!m_valid && t < 100) begin @(negedge clk); t++; end
      if (t >= 100) chk("drain_timeout", 1'b0, 1'b1);
      chk("m_data", m_data, (i == 0) ? first : base + 64'(i));
      chk("m_last", m_last, i == n - 1);
      @(posedge clk);
    end
    #1 m_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_awready_grant0", awready, 1'b0);
    grant = 1'b1; #1;
    chk("rst_awready_grant1", awready, 1'b1);
    chk("rst_wready", wready, 1'b0);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_bresp", bresp, 2'b00);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_last", m_last, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    // Single burst then drain 0..15
    burst(16, 64'd0, 2'b01, 3'd3, 2'b00);
    chk("t1_m_valid_full", m_valid, 1'b1);
    drain(16, 64'd0, 64'd0);
    #1 chk("t1_m_valid_empty", m_valid, 1'b0);

    // Both banks full
    burst(16, 64'd100, 2'b01, 3'd3, 2'b00);
    burst(16, 64'd200, 2'b01, 3'd3, 2'b00);
    send_aw(2'b01, 3'd3, 8'd15);
    repeat (3) begin
      @(negedge clk);
      chk("t2_wready_blocked", wready, 1'b0);
      chk("t2_bvalid_blocked", bvalid, 1'b0);
    end
    drain(16, 64'd100, 64'd100);
    @(negedge clk);
    chk("t2_wready_resumed", wready, 1'b1);
    for (int i = 0; i < 16; i++) w_beat(64'd300 + 64'(i), 8'hFF, i == 15);
    check_b(2'b00);
    drain(16, 64'd200, 64'd200);
    drain(16, 64'd300, 64'd300);

    // Burst split across banks
    burst(8, 64'd400, 2'b01, 3'd3, 2'b00);
    chk("t3_partial_no_valid", m_valid, 1'b0);
    burst(24, 64'd408, 2'b01, 3'd3, 2'b00);
    drain(16, 64'd400, 64'd400);
    drain(16, 64'd416, 64'd416);

    // Byte strobes on slot 0 of the same bank, two fills apart
    send_aw(2'b01, 3'd3, 8'd15);
    w_beat(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0);
    for (int i = 1; i < 16; i++) w_beat(64'd900 + 64'(i), 8'hFF, i == 15);
    check_b(2'b00);
    drain(16, 64'd900, 64'hFFFF_FFFF_FFFF_FFFF);
    burst(16, 64'd1000, 2'b01, 3'd3, 2'b00);
    drain(16, 64'd1000, 64'd1000);
    send_aw(2'b01, 3'd3, 8'd15);
    w_beat(64'd0, 8'h0F, 1'b0);
    for (int i = 1; i < 16; i++) w_beat(64'd1100 + 64'(i), 8'hFF, i == 15);
    check_b(2'b00);
    drain(16, 64'd1100, 64'hFFFF_FFFF_0000_0000);

    // Error bursts: discarded, SLVERR, fill index untouched
    burst(4, 64'hBAD0, 2'b00, 3'd3, 2'b10);
    burst(4, 64'hBAD8, 2'b01, 3'd2, 2'b10);
    send_aw(2'b01, 3'd3, 8'd15);
    for (int i = 0; i < 15; i++) w_beat(64'd500 + 64'(i), 8'hFF, 1'b0);
    chk("t5_not_full_after_15", m_valid, 1'b0);
    w_beat(64'd515, 8'hFF, 1'b1);
    check_b(2'b00);
    drain(16, 64'd500, 64'd500);

    // Asynchronous reset mid-burst with a full bank pending
    burst(16, 64'd600, 2'b01, 3'd3, 2'b00);
    chk("t6_full_before_reset", m_valid, 1'b1);
    send_aw(2'b01, 3'd3, 8'd15);
    for (int i = 0; i < 5; i++) w_beat(64'd700 + 64'(i), 8'hFF, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_m_valid", m_valid, 1'b0);
    chk("t6_rst_wready", wready, 1'b0);
    chk("t6_rst_awready", awready, 1'b1);
    @(negedge clk); rst_n = 1'b1;
    burst(16, 64'd800, 2'b01, 3'd3, 2'b00);
    drain(16, 64'd800, 64'd800);

`ifdef PPBUF_FLUSH_EN
    // Flush ignored with an empty fill bank, then closes a 5-word bank
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    chk("t7_flush_idx0_ignored", m_valid, 1'b0);
    burst(5, 64'd1200, 2'b01, 3'd3, 2'b00);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    chk("t7_flush_valid", m_valid, 1'b1);
    drain(5, 64'd1200, 64'd1200);
    burst(16, 64'd1300, 2'b01, 3'd3, 2'b00);
    drain(16, 64'd1300, 64'd1300);
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
